key_led_gpio_ctrl: RTL and testbench
====================================

// Module: key_led_gpio_ctrl
// PURPOSE
//  Parametrised key/LED front-end between board pins and the EMPU GPIO bank.
//  Debounces NUM_KEYS active-low push-buttons and reports level, one-cycle press pulse and sticky press flag.
//  Drives NUM_LEDS LEDs, each in its own mode: off, on, blink or PWM dim.
//  Sits at top level beside Gowin_EMPU_Top; GPIO outputs feed the mode/duty/clear inputs, status feeds gpioin.
// PARAMETERS
//  NUM_KEYS        4        number of key inputs (1..8)
//  NUM_LEDS        3        number of LED outputs (1..8)
//  DEBOUNCE_CYCLES 500000   stable cycles required to accept a key level change (>=2)
//  BLINK_HALF      12500000 cycles per blink half-period (>=1)
//  PWM_DIV         16       sys_clk cycles per PWM counter step (>=1)
// PORTS
//  sys_clk_i       in   1            system clock
//  reset_n_i       in   1            synchronous reset, active-low
//  key_raw_i       in   NUM_KEYS     raw key pins, 0 = pressed, asynchronous
//  evt_clr_i       in   NUM_KEYS     per-key sticky flag clear, level, active-high
//  led_mode_i      in   2*NUM_LEDS   2 bits per LED: 00 off, 01 on, 10 blink, 11 pwm
//  led_duty_i      in   8            shared PWM duty, 0..255
//  key_state_o     out  NUM_KEYS     debounced level, 1 = pressed
//  key_press_o     out  NUM_KEYS     1-cycle pulse on debounced release->press
//  key_evt_o       out  NUM_KEYS     sticky press flag
//  led_o           out  NUM_LEDS     LED drive, 1 = lit
//  led_en_o        out  1            LED bank enable, active-low
// BEHAVIOUR
//  - Reset (reset_n_i=0 at a sys_clk_i edge): all of key_state_o, key_press_o, key_evt_o, led_o = 0; led_en_o = 1;
//    sync flops = 1 (released); all counters = 0. Reset mid-debounce discards the pending change.
//  - led_en_o = 0 from the first edge after reset deasserts.
//  - Per key: 2-flop synchroniser on key_raw_i -> s. Counter cnt (clog2(DEBOUNCE_CYCLES) bits):
//    s == stable -> cnt <= 0; s != stable and cnt < D-1 -> cnt <= cnt+1;
//    s != stable and cnt == D-1 -> stable <= s, cnt <= 0.
//    Any bounce back to stable level before D cycles restarts count; no output change.
//  - Latency: raw change sampled at edge N -> key_state_o updates at edge N+D+2.
//  - key_press_o is registered, high for exactly the cycle in which stable goes released->pressed. No pulse on release.
//  - key_evt_o[i]: set by key_press_o[i], cleared by evt_clr_i[i]; simultaneous set and clear -> set wins.
//  - Blink: one shared prescaler 0..BLINK_HALF-1; phase toggles at wrap; phase = 0 after reset. Phase is global;
//    changing a mode never resets it.
//  - PWM: shared prescaler 0..PWM_DIV-1; 8-bit pwm_cnt increments at prescaler wrap, wraps 255->0.
//    pwm_on = (pwm_cnt < led_duty_i): duty 0 -> always off; duty 255 -> on 255 of 256 steps.
//  - led_o registered: 00->0, 01->1, 10->phase, 11->pwm_on; one cycle from led_mode_i/led_duty_i change to led_o.
//  - All keys and LEDs independent; simultaneous events on different channels never interact.
// STRUCTURE
//  - Package key_led_pkg: LED_OFF/LED_ON/LED_BLINK/LED_PWM 2-bit localparams, PWM_W=8.
//  - Sub-module key_debounce (sync + counter + stable + press pulse), generate-instantiated NUM_KEYS times.
//  - Top: sticky flags, blink and PWM prescalers, per-LED output mux.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, BLINK_HALF=3, PWM_DIV=1)
//  1 reset held 3 cycles, keys high -> all outputs 0, led_en_o=1; first edge after release -> led_en_o=0.
//  2 key_raw_i[0] 1->0 held -> key_state_o[0]=1 at edge N+6; key_press_o[0] high that cycle only; key_evt_o[0]=1 stays.
//  3 key_raw_i[1] low 3 cycles then high (bounce) -> key_state_o[1], key_press_o[1] remain 0.
//  4 evt_clr_i[0]=1 in same cycle as a new press pulse on key 0 -> key_evt_o[0]=1; clear next cycle alone -> 0.
//  5 led_mode_i=10_01_00 -> led_o[0]=0, led_o[1]=1, led_o[2] toggles every 3 cycles.
//  6 all LEDs mode 11, duty=64 -> each LED high exactly 64 of 256 cycles; duty=0 -> never high; reset mid-press -> state 0.

Source files
------------

// File: rtl/key_led_pkg.sv
// Shared constants for the key/LED GPIO front-end: LED mode encodings and PWM width.
package key_led_pkg;

  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_ON    = 2'b01;
  localparam logic [1:0] LED_BLINK = 2'b10;
  localparam logic [1:0] LED_PWM   = 2'b11;

  localparam int PWM_W = 8;

  // Counter width for a modulus n; never below one bit so n == 1 still builds.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level and
// a single-cycle press pulse on the released->pressed transition.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_state,
  output logic key_press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          stable;
  logic [CW-1:0] cnt;

  // stable holds the raw pin polarity (1 = released); outputs are inverted to 1 = pressed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      stable    <= 1'b1;
      cnt       <= '0;
      key_state <= 1'b0;
      key_press <= 1'b0;
    end else begin
      sync_1 <= key_raw;
      sync_2 <= sync_1;
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      key_state <= ~stable;
      key_press <= ~stable & ~key_state;
    end
  end

endmodule

// File: rtl/key_led_gpio_ctrl.sv
// Key/LED front-end beside the EMPU GPIO bank: debounced keys with sticky press
// flags, and per-LED off/on/blink/PWM drive from shared prescalers.
module key_led_gpio_ctrl
  import key_led_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_LEDS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_HALF      = 12500000,
  parameter int PWM_DIV         = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  reset_n_i,
  input  logic [NUM_KEYS-1:0]   key_raw_i,
  input  logic [NUM_KEYS-1:0]   evt_clr_i,
  input  logic [2*NUM_LEDS-1:0] led_mode_i,
  input  logic [PWM_W-1:0]      led_duty_i,
  output logic [NUM_KEYS-1:0]   key_state_o,
  output logic [NUM_KEYS-1:0]   key_press_o,
  output logic [NUM_KEYS-1:0]   key_evt_o,
  output logic [NUM_LEDS-1:0]   led_o,
  output logic                  led_en_o
);

  localparam int BW = cnt_width(BLINK_HALF);
  localparam int PW = cnt_width(PWM_DIV);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(PWM_DIV - 1);

  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic [PW-1:0]       pwm_pre;
  logic [PWM_W-1:0]    pwm_cnt;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] led_next;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk      (sys_clk_i),
      .reset_n  (reset_n_i),
      .key_raw  (key_raw_i[i]),
      .key_state(key_state_o[i]),
      .key_press(key_press_o[i])
    );
  end

  // A press arriving together with a clear keeps the flag set.
  always_ff @(posedge sys_clk_i) begin
    if (!reset_n_i) begin
      key_evt_o <= '0;
    end else begin
      key_evt_o <= (key_evt_o & ~evt_clr_i) | key_press_o;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!reset_n_i) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_pre     <= '0;
      pwm_cnt     <= '0;
      led_en_o    <= 1'b1;
    end else begin
      led_en_o <= 1'b0;
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if (pwm_pre == PRE_MAX) begin
        pwm_pre <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        pwm_pre <= pwm_pre + 1'b1;
      end
    end
  end

  assign pwm_on = (pwm_cnt < led_duty_i);

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (led_mode_i[2*i +: 2])
        LED_OFF:   led_next[i] = 1'b0;
        LED_ON:    led_next[i] = 1'b1;
        LED_BLINK: led_next[i] = blink_phase;
        LED_PWM:   led_next[i] = pwm_on;
        default:   led_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!reset_n_i) begin
      led_o <= '0;
    end else begin
      led_o <= led_next;
    end
  end

endmodule

// File: tb/tb_key_led_gpio_ctrl.sv
// Directed bench for key_led_gpio_ctrl with small debounce/blink/PWM constants.
module tb_key_led_gpio_ctrl;

  logic       sys_clk;
  logic       reset_n;
  logic [3:0] key_raw;
  logic [3:0] evt_clr;
  logic [5:0] led_mode;
  logic [7:0] led_duty;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_evt;
  logic [2:0] led;
  logic       led_en;

  int checks;
  int errors;
  int k;
  int hi_cnt [3];

  logic [11:0] exp_q[$];
  logic [2:0]  led_q[$];

  key_led_gpio_ctrl #(
    .NUM_KEYS       (4),
    .NUM_LEDS       (3),
    .DEBOUNCE_CYCLES(4),
    .BLINK_HALF     (3),
    .PWM_DIV        (1)
  ) dut (
    .sys_clk_i  (sys_clk),
    .reset_n_i  (reset_n),
    .key_raw_i  (key_raw),
    .evt_clr_i  (evt_clr),
    .led_mode_i (led_mode),
    .led_duty_i (led_duty),
    .key_state_o(key_state),
    .key_press_o(key_press),
    .key_evt_o  (key_evt),
    .led_o      (led),
    .led_en_o   (led_en)
  );

  // clock / reset-relative edge index
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // k = number of edges since reset released (edge E_k leaves k here)
  always @(posedge sys_clk) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] kv(input logic [3:0] st, input logic [3:0] pr, input logic [3:0] ev);
    return {ev, pr, st};
  endfunction

  task automatic key_step(input string tag, input logic [11:0] e);
    logic [11:0] got;
    exp_q.push_back(e);
    tick();
    got = exp_q.pop_front();
    chk(tag, {20'd0, key_evt, key_press, key_state}, {20'd0, got});
  endtask

  task automatic led_step(input string tag, input logic [2:0] e);
    logic [2:0] got;
    led_q.push_back(e);
    tick();
    got = led_q.pop_front();
    chk(tag, {29'd0, led}, {29'd0, got});
    for (int i = 0; i < 3; i++) hi_cnt[i] += int'(led[i]);
  endtask

  initial begin
    logic ph;
    logic pw;
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    key_raw  = 4'hf;
    evt_clr  = 4'h0;
    led_mode = 6'b0;
    led_duty = 8'd0;

    // reset
    repeat (3) tick();
    chk("rst_keys", {20'd0, key_evt, key_press, key_state}, 32'd0);
    chk("rst_led", {29'd0, led}, 32'd0);
    chk("rst_en", {31'd0, led_en}, 32'd1);
    reset_n = 1'b1;
    tick();
    chk("en_low", {31'd0, led_en}, 32'd0);

    // key 0 press: state/pulse at N+6, flag from N+7
    key_raw[0] = 1'b0;
    for (int j = 0; j <= 8; j++)
      key_step("press0", kv({3'b0, j >= 6}, {3'b0, j == 6}, {3'b0, j >= 7}));

    // key 1 bounce: three low samples never qualify
    key_raw[1] = 1'b0;
    for (int j = 0; j < 3; j++) key_step("bounce1", kv(4'b0001, 4'b0, 4'b0001));
    key_raw[1] = 1'b1;
    for (int j = 0; j < 8; j++) key_step("bounce1", kv(4'b0001, 4'b0, 4'b0001));

    // key 0 release: no pulse, flag persists
    key_raw[0] = 1'b1;
    for (int j = 0; j <= 7; j++)
      key_step("release0", kv({3'b0, j < 6}, 4'b0, 4'b0001));
    evt_clr[0] = 1'b1;
    key_step("clr0", kv(4'b0, 4'b0, 4'b0));
    evt_clr[0] = 1'b0;

    // clear coincident with the press pulse, then clear alone
    key_raw[0] = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      evt_clr[0] = (j == 7) || (j == 8);
      key_step("clr_race", kv({3'b0, j >= 6}, {3'b0, j == 6}, {3'b0, j == 7}));
    end
    evt_clr = 4'h0;

    // LEDs: off / on / blink
    led_mode = {2'b10, 2'b01, 2'b00};
    for (int j = 0; j < 12; j++) begin
      ph = ((k / 3) % 2) == 1;
      led_step("blink", {ph, 1'b1, 1'b0});
    end

    // PWM duty 64 over one full 256-step period
    led_mode = 6'b111111;
    led_duty = 8'd64;
    for (int i = 0; i < 3; i++) hi_cnt[i] = 0;
    for (int j = 0; j < 256; j++) begin
      pw = (k % 256) < 64;
      led_step("pwm64", {pw, pw, pw});
    end
    for (int i = 0; i < 3; i++) chk($sformatf("pwm64_cnt%0d", i), hi_cnt[i], 32'd64);

    // PWM duty 0
    led_duty = 8'd0;
    for (int i = 0; i < 3; i++) hi_cnt[i] = 0;
    for (int j = 0; j < 256; j++) led_step("pwm0", 3'b000);
    for (int i = 0; i < 3; i++) chk($sformatf("pwm0_cnt%0d", i), hi_cnt[i], 32'd0);

    // reset during a pending key 2 press, with key 0 held down
    key_raw[2] = 1'b0;
    for (int j = 0; j < 3; j++) key_step("pend2", kv(4'b0001, 4'b0, 4'b0));
    reset_n = 1'b0;
    key_raw = 4'hf;
    tick();
    chk("midrst_keys", {20'd0, key_evt, key_press, key_state}, 32'd0);
    chk("midrst_led", {29'd0, led}, 32'd0);
    chk("midrst_en", {31'd0, led_en}, 32'd1);
    reset_n = 1'b1;
    for (int j = 0; j < 8; j++) key_step("post_rst", kv(4'b0, 4'b0, 4'b0));
    chk("post_rst_en", {31'd0, led_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
